// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: shares the LC-3 single-port memory between CPU and debug port.
// Optional macro LC3_MEM_ARB_RR_EN selects round-robin arbitration (default: CPU priority).
module lc3_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_done,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t state;
  state_t nextState;

  // owner: 1 = CPU, 0 = debug
  logic              owner;
  logic              latWe;
  logic [ADDR_W-1:0] latAddr;
  logic [DATA_W-1:0] latWdata;
  logic [2:0]        waitCnt;
  logic [DATA_W-1:0] rdReg;
  logic              anyReq;
  logic              grantCpu;
  logic              take;

  assign anyReq = cpu_req | dbg_req;
  assign take   = (state == IDLE) && anyReq;

`ifdef LC3_MEM_ARB_RR_EN
  logic lastCpu;

  // Ties go to whichever port was not granted last
  always_comb begin
    grantCpu = cpu_req && (!dbg_req || !lastCpu);
  end

  // Remember the most recent winner at every grant
  always_ff @(posedge clk) begin
    if (reset) begin
      lastCpu <= 1'b0;
    end else if (take) begin
      lastCpu <= grantCpu;
    end
  end
`else
  // Fixed priority: CPU always wins a tie
  always_comb begin
    grantCpu = cpu_req;
  end
`endif

  // Next-state logic for the transaction sequencer
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:  if (anyReq) nextState = ISSUE;
      ISSUE: nextState = WAIT;
      WAIT:  if (waitCnt == 3'd0) nextState = RESP;
      RESP:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Latch the winning request, run the latency counter, capture read data
  always_ff @(posedge clk) begin
    if (reset) begin
      owner    <= 1'b0;
      latWe    <= 1'b0;
      latAddr  <= '0;
      latWdata <= '0;
      waitCnt  <= 3'd0;
      rdReg    <= '0;
    end else begin
      if (take) begin
        owner    <= grantCpu;
        latWe    <= grantCpu ? cpu_we : dbg_we;
        latAddr  <= grantCpu ? cpu_addr : dbg_addr;
        latWdata <= grantCpu ? cpu_wdata : dbg_wdata;
      end
      if (state == ISSUE) begin
        waitCnt <= LAT_M1;
      end else if (state == WAIT) begin
        if (waitCnt == 3'd0) begin
          rdReg <= mem_rdata;
        end else begin
          waitCnt <= waitCnt - 3'd1;
        end
      end
    end
  end

  // Memory port is driven only during ISSUE and is zero otherwise
  assign mem_en    = (state == ISSUE);
  assign mem_we    = mem_en & latWe;
  assign mem_addr  = mem_en ? latAddr : '0;
  assign mem_wdata = mem_en ? latWdata : '0;

  assign cpu_done  = (state == RESP) && owner;
  assign dbg_done  = (state == RESP) && !owner;
  assign cpu_rdata = rdReg;
  assign dbg_rdata = rdReg;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb_lc3_mem_arbiter: vector table + scoreboard bench for lc3_mem_arbiter.
// Instance u1 uses MEM_LAT=1 with a memory model; u3 uses MEM_LAT=3.
module tb_lc3_mem_arbiter;

`ifdef LC3_MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_done;
  logic [15:0] cpu_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [15:0] dbg_addr = '0, dbg_wdata = '0;
  logic        dbg_done;
  logic [15:0] dbg_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        busy;

  logic        dbgReq3 = 1'b0;
  logic        cpuDone3, dbgDone3;
  logic [15:0] cpuRdata3, dbgRdata3;
  logic        memEn3, memWe3;
  logic [15:0] memAddr3, memWdata3;
  logic        busy3;
  logic [15:0] cyc = '0;

  int nCmp = 0;
  int nBad = 0;
  int idleBad = 0;
  bit saw20 = 1'b0;
  bit cpu3Seen = 1'b0;

  always #5 clk = ~clk;

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) u3 (
    .clk(clk), .reset(reset),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(16'h0000),
    .cpu_wdata(16'h0000), .cpu_done(cpuDone3), .cpu_rdata(cpuRdata3),
    .dbg_req(dbgReq3), .dbg_we(1'b0), .dbg_addr(dbg_addr),
    .dbg_wdata(16'h0000), .dbg_done(dbgDone3), .dbg_rdata(dbgRdata3),
    .mem_en(memEn3), .mem_we(memWe3), .mem_addr(memAddr3),
    .mem_wdata(memWdata3), .mem_rdata(cyc), .busy(busy3)
  );

  // Synchronous memory, one cycle read latency
  logic [15:0] memArr [0:255];
  initial for (int i = 0; i < 256; i++) memArr[i] = 16'h0000;

  always @(posedge clk) begin
    cyc <= cyc + 16'd1;
    if (mem_en) begin
      if (mem_we) memArr[mem_addr[7:0]] <= mem_wdata;
      else mem_rdata <= memArr[mem_addr[7:0]];
    end
  end

  typedef struct {
    logic        own;
    logic        we;
    logic [15:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  typedef struct {
    bit          rst;
    bit          cpu;
    bit          dbg;
    bit          we;
    logic [15:0] cAddr;
    logic [15:0] dAddr;
    logic [15:0] wdata;
    bit          own;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input longint act, input longint exp);
    nCmp++;
    if (act != exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard consumer and always-on port sanity monitor
  always @(negedge clk) begin
    if (cpu_done || dbg_done) begin
      if (sb.size() == 0) begin
        check("unexpectedDone", 1, 0);
      end else begin
        e = sb.pop_front();
        check("bothDone", longint'(cpu_done & dbg_done), 0);
        check("doneOwner", longint'(cpu_done), longint'(e.own));
        if (!e.we)
          check("rdata", e.own ? cpu_rdata : dbg_rdata, e.rdata);
      end
    end
    if (!mem_en && (mem_we || mem_addr != 0 || mem_wdata != 0)) idleBad++;
    if (!memEn3 && (memWe3 || memAddr3 != 0 || memWdata3 != 0)) idleBad++;
    if (mem_en && mem_addr == 16'h0020) saw20 = 1'b1;
    if (cpuDone3) cpu3Seen = 1'b1;
  end

  task automatic waitDone(output int n, output int enAt, output int enCnt);
    n = 0;
    enAt = -1;
    enCnt = 0;
    while (n < 20 && !(cpu_done || dbg_done)) begin
      @(negedge clk);
      n++;
      if (mem_en) begin
        enCnt++;
        if (enAt < 0) enAt = n;
      end
    end
  endtask

  task automatic applyVec(input vec_t v);
    int n, enAt, enCnt;
    if (v.rst) begin
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
    end
    cpu_we = v.we; cpu_addr = v.cAddr; cpu_wdata = v.wdata;
    dbg_we = v.we; dbg_addr = v.dAddr; dbg_wdata = v.wdata;
    sb.push_back('{v.own, v.we, v.rdata});
    cpu_req = v.cpu;
    dbg_req = v.dbg;
    waitDone(n, enAt, enCnt);
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    check("latency", n, 3);
    check("memEnCycle", enAt, 1);
    check("memEnCount", enCnt, 1);
    @(negedge clk);
  endtask

  initial begin
    int n, enAt, enCnt;
    logic [15:0] expR;

    vecs[0] = '{0, 1, 0, 1, 16'h3000, 16'h0000, 16'hBEEF, 1, 16'h0000};
    vecs[1] = '{0, 1, 0, 0, 16'h3000, 16'h0000, 16'h0000, 1, 16'hBEEF};
    vecs[2] = '{0, 0, 1, 1, 16'h0000, 16'h0010, 16'h1234, 0, 16'h0000};
    vecs[3] = '{0, 0, 1, 0, 16'h0000, 16'h0010, 16'h0000, 0, 16'h1234};
    vecs[4] = '{0, 1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 1, 16'h1234};
    vecs[5] = '{1, 1, 1, 0, 16'h3000, 16'h0010, 16'h0000, 1, 16'hBEEF};
    vecs[6] = '{0, 1, 1, 0, 16'h3000, 16'h0010, 16'h0000, !RR,
                RR ? 16'h1234 : 16'hBEEF};
    vecs[7] = '{0, 1, 1, 0, 16'h3000, 16'h0010, 16'h0000, 1, 16'hBEEF};
    vecs[8] = '{0, 1, 1, 0, 16'h3000, 16'h0010, 16'h0000, !RR,
                RR ? 16'h1234 : 16'hBEEF};
    vecs[9] = '{0, 0, 1, 0, 16'h0000, 16'h3000, 16'h0000, 0, 16'hBEEF};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("resetIdle1", longint'(|{cpu_done, dbg_done, cpu_rdata, dbg_rdata,
            mem_en, mem_we, mem_addr, mem_wdata, busy}), 0);
      check("resetIdle3", longint'(|{cpuDone3, dbgDone3, cpuRdata3,
            dbgRdata3, memEn3, busy3}), 0);
    end

    for (int i = 0; i < 10; i++) applyVec(vecs[i]);

    // Address change during WAIT must not disturb the latched transaction
    cpu_we = 1'b0;
    cpu_addr = 16'h0010;
    sb.push_back('{1'b1, 1'b0, 16'h1234});
    cpu_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cpu_addr = 16'h0020;
    waitDone(n, enAt, enCnt);
    cpu_req = 1'b0;
    check("addrHoldLatency", n, 1);
    check("never0020", longint'(saw20), 0);
    @(negedge clk);

    // Reset during WAIT of a read: no done pulse, outputs back to reset values
    cpu_addr = 16'h3000;
    cpu_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midWaitBusy", longint'(busy), 1);
    reset = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    check("rstBusy", longint'(busy), 0);
    check("rstDone", longint'(cpu_done | dbg_done), 0);
    check("rstMemEn", longint'(mem_en), 0);
    check("rstRdata", cpu_rdata, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rstNoDone", longint'(cpu_done | dbg_done), 0);
    applyVec('{0, 1, 0, 0, 16'h3000, 16'h0000, 16'h0000, 1, 16'hBEEF});

    // MEM_LAT=3 debug read on u3
    dbg_addr = 16'h0040;
    dbgReq3 = 1'b1;
    n = 0;
    enAt = -1;
    expR = 16'h0000;
    while (n < 20 && !dbgDone3) begin
      @(negedge clk);
      n++;
      if (memEn3 && enAt < 0) begin
        enAt = n;
        expR = cyc + 16'd3;
      end
    end
    dbgReq3 = 1'b0;
    check("lat3Done", n, 5);
    check("lat3MemEn", enAt, 1);
    check("lat3Rdata", dbgRdata3, expR);
    check("lat3CpuDone", longint'(cpu3Seen), 0);
    repeat (3) @(negedge clk);

    check("idlePortsZero", idleBad, 0);
    check("sbEmpty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
